// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   tx_feed_state_t : handshake states of the transmit feeder
//   TX_FIFO_DEPTH   : default depth of the transmit byte FIFO
//   UART_DW         : character width shared by uart_tx / uart_rx
package uart_pkg;

    localparam int UART_DW       = 8;
    localparam int TX_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2
    } tx_feed_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single level signal crossing into clk.
//   clk : destination clock
//   rst : asynchronous active-high reset, loads RST_VAL into both flops
//   d   : asynchronous input level
//   q   : synchronized level, two clk edges behind d
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus start/done handshake in front of the UART transmitter.
// Host bytes are queued one per clk; the FSM hands them to the transmitter
// one at a time and waits for the (tx_clk domain) done level to cycle.
//   clk, rst      : system clock, asynchronous active-high reset
//   wr_en/wr_data : push request and byte
//   full/empty    : registered FIFO occupancy flags
//   count         : registered occupancy
//   overflow      : one-cycle pulse when a push is dropped
//   tx_start      : held start request to the transmitter
//   tx_data       : byte under transmission, stable while tx_start=1
//   tx_done       : transmitter idle/complete level (async)
//   tx_err        : transmitter error level (async)
//   busy          : a byte is in the handshake
//   err_sticky    : latched transmitter error, cleared by err_clr
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DEPTH = TX_FIFO_DEPTH,
    parameter  int DW    = UART_DW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          tx_start,
    output logic [DW-1:0] tx_data,
    input  logic          tx_done,
    input  logic          tx_err,
    output logic          busy,
    output logic          err_sticky,
    input  logic          err_clr
);

    localparam int AW = $clog2(DEPTH);

    tx_feed_state_t state;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          done_s;
    logic          err_s;
    logic          pop;
    logic          push;

    // done idles high so a freshly reset feeder may start immediately.
    uart_sync2 #(.RST_VAL(1'b1)) u_sync_done (
        .clk (clk),
        .rst (rst),
        .d   (tx_done),
        .q   (done_s)
    );

    uart_sync2 #(.RST_VAL(1'b0)) u_sync_err (
        .clk (clk),
        .rst (rst),
        .d   (tx_err),
        .q   (err_s)
    );

    // A push while full is still taken if the head leaves in the same cycle.
    assign pop  = (state == IDLE) && !empty && done_s;
    assign push = wr_en && (!full || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO control: pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            full     <= (count_next == CW'(DEPTH));
            empty    <= (count_next == '0);
            overflow <= wr_en && !push;
        end
    end

    // Handshake FSM: IDLE pops, REQ holds start until the transmitter
    // reports busy, WAIT_DONE waits for it to go idle again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (!done_s) begin
                        tx_start <= 1'b0;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (done_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Set has priority over clear so an error present during a clear is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (err_s) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule
